// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Write-side front end of the integer register file. Merges single-cycle
//   EX results and long-latency (load/divide) results into the single write
//   port. Long-latency results that lose to EX are buffered in a small FIFO.
//   A busy scoreboard reports in-flight long-latency destinations to ID.
//
// Handshake: the lg_* channel is valid/ready. A transfer happens in any cycle
//   with lg_valid && lg_ready. The producer holds lg_rd/lg_wdata stable while
//   lg_valid is high and ready is low. EX has no backpressure.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ex_wen/ex_rd/ex_wdata EX result (priority source)
//   lg_valid/lg_ready/lg_rd/lg_wdata  long-latency result channel
//   iss_valid/iss_rd      long-latency issue (sets scoreboard bit)
//   rs1_raddr/rs2_raddr   ID source addresses
//   rs1_busy/rs2_busy     registered scoreboard lookups
//   stall_req             FIFO starved by EX for STARVE_MAX cycles
//   wen/rd_waddr/rd_wdata register file write port
//   dbg_count/dbg_starve  FIFO occupancy and starve counter for checkers
//
// Optional: define WB_STATS_EN to add stat_ex_wr, stat_lg_wr, stat_conflict
//   32-bit wrapping event counters.
// ---------------------------------------------------------------------------
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_wen,
  input  logic [`RegAddrBus] ex_rd,
  input  logic [`RegBus]     ex_wdata,
  input  logic               lg_valid,
  output logic               lg_ready,
  input  logic [`RegAddrBus] lg_rd,
  input  logic [`RegBus]     lg_wdata,
  input  logic               iss_valid,
  input  logic [`RegAddrBus] iss_rd,
  input  logic [`RegAddrBus] rs1_raddr,
  input  logic [`RegAddrBus] rs2_raddr,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               stall_req,
  output logic               wen,
  output logic [`RegAddrBus] rd_waddr,
  output logic [`RegBus]     rd_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
  output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve
`ifdef WB_STATS_EN
  ,
  output logic [31:0]        stat_ex_wr,
  output logic [31:0]        stat_lg_wr,
  output logic [31:0]        stat_conflict
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [4:0]    r_mem_rd   [FIFO_DEPTH];
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_sb;
  logic [SW-1:0] r_starve;

  logic          w_ex_sel, w_empty, w_full, w_pop, w_bypass, w_push;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_sb_next;
  logic          w_clr;
  logic [4:0]    w_clr_rd;

  assign w_head_rd   = r_mem_rd[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == DEPTH_C);

  // An EX write to x0 is treated as idle so a waiting long result can go.
  assign w_ex_sel = ex_wen && (ex_rd != 5'd0);
  assign w_pop    = !rst && !w_ex_sel && !w_empty;
  assign w_bypass = !rst && !w_ex_sel && w_empty && lg_valid;
  assign lg_ready = !rst && (!w_full || w_pop);
  assign w_push   = lg_valid && lg_ready && !w_bypass;

  // Write port mux; rd=0 entries are consumed but never written.
  always_comb begin
    wen      = 1'b0;
    rd_waddr = 5'd0;
    rd_wdata = 32'd0;
    if (!rst) begin
      if (w_ex_sel) begin
        wen      = 1'b1;
        rd_waddr = ex_rd;
        rd_wdata = ex_wdata;
      end else if (w_pop) begin
        wen      = (w_head_rd != 5'd0);
        rd_waddr = w_head_rd;
        rd_wdata = w_head_data;
      end else if (w_bypass) begin
        wen      = (lg_rd != 5'd0);
        rd_waddr = lg_rd;
        rd_wdata = lg_wdata;
      end
    end
  end

  // Scoreboard next state: clear first so a same-cycle set wins.
  always_comb begin
    w_clr    = w_pop || w_bypass;
    w_clr_rd = w_pop ? w_head_rd : lg_rd;
    w_sb_next = r_sb;
    if (w_clr) w_sb_next[w_clr_rd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) w_sb_next[iss_rd] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_sb     <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) begin
        r_mem_rd[r_wptr]   <= lg_rd;
        r_mem_data[r_wptr] <= lg_wdata;
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      r_sb <= w_sb_next;
      // Non-empty and no pop means EX took the port this cycle.
      if (w_empty || w_pop)      r_starve <= '0;
      else if (r_starve != SMAX_C) r_starve <= r_starve + 1'b1;
    end
  end

  assign rs1_busy   = !rst && r_sb[rs1_raddr];
  assign rs2_busy   = !rst && r_sb[rs2_raddr];
  assign stall_req  = !rst && (r_starve == SMAX_C);
  assign dbg_count  = r_count;
  assign dbg_starve = r_starve;

`ifdef WB_STATS_EN
  logic w_lg_wr;
  assign w_lg_wr = wen && !w_ex_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ex_wr    <= '0;
      stat_lg_wr    <= '0;
      stat_conflict <= '0;
    end else begin
      if (w_ex_sel) stat_ex_wr <= stat_ex_wr + 32'd1;
      if (w_lg_wr)  stat_lg_wr <= stat_lg_wr + 32'd1;
      if (w_ex_sel && (!w_empty || lg_valid))
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed bench for rf_wb_arbiter. Inputs change 1ns after the rising
//   edge; combinational outputs are sampled 2ns later, well before the next
//   edge. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic        lg_valid;
  logic        lg_ready;
  logic [4:0]  lg_rd;
  logic [31:0] lg_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1_raddr, rs2_raddr;
  logic        rs1_busy, rs2_busy;
  logic        stall_req;
  logic        wen;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [1:0]  dbg_count;
  logic [2:0]  dbg_starve;
`ifdef WB_STATS_EN
  logic [31:0] stat_ex_wr, stat_lg_wr, stat_conflict;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_wdata(ex_wdata),
    .lg_valid(lg_valid), .lg_ready(lg_ready), .lg_rd(lg_rd), .lg_wdata(lg_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_raddr(rs1_raddr), .rs2_raddr(rs2_raddr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall_req(stall_req),
    .wen(wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .dbg_count(dbg_count), .dbg_starve(dbg_starve)
`ifdef WB_STATS_EN
    , .stat_ex_wr(stat_ex_wr), .stat_lg_wr(stat_lg_wr), .stat_conflict(stat_conflict)
`endif
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    ex_wen = 1'b0; ex_rd = 5'd0; ex_wdata = 32'd0;
    lg_valid = 1'b0; lg_rd = 5'd0; lg_wdata = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic [31:0] d);
    ex_wen = 1'b1; ex_rd = rd; ex_wdata = d;
  endtask

  task automatic drive_lg(input logic [4:0] rd, input logic [31:0] d);
    lg_valid = 1'b1; lg_rd = rd; lg_wdata = d;
  endtask

  task automatic drive_iss(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
  endtask

  // ---- checker ----
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rs1_raddr = 5'd0; rs2_raddr = 5'd0;

    // Reset forces outputs even with active inputs.
    tick();
    drive_ex(5'd5, 32'h1111_1111); drive_lg(5'd6, 32'h2222_2222);
    settle();
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_waddr", {27'd0, rd_waddr}, 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    chk("rst_lg_ready", {31'd0, lg_ready}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    tick();
    rst = 1'b0; idle();
    settle();
    chk("post_rst_wen", {31'd0, wen}, 32'd0);
    chk("post_rst_lg_ready", {31'd0, lg_ready}, 32'd1);

    // EX only.
    tick();
    drive_ex(5'd5, 32'h1234_5678);
    settle();
    chk("ex_wen", {31'd0, wen}, 32'd1);
    chk("ex_waddr", {27'd0, rd_waddr}, 32'd5);
    chk("ex_wdata", rd_wdata, 32'h1234_5678);

    // Bypass.
    tick();
    idle(); drive_lg(5'd7, 32'hA5A5_A5A5);
    settle();
    chk("byp_wen", {31'd0, wen}, 32'd1);
    chk("byp_waddr", {27'd0, rd_waddr}, 32'd7);
    chk("byp_wdata", rd_wdata, 32'hA5A5_A5A5);
    chk("byp_lg_ready", {31'd0, lg_ready}, 32'd1);
    tick();
    idle();
    settle();
    chk("byp_fifo_empty_wen", {31'd0, wen}, 32'd0);
    chk("byp_fifo_empty_cnt", {30'd0, dbg_count}, 32'd0);

    // Scoreboard set, no same-cycle forwarding.
    tick();
    drive_iss(5'd9); rs1_raddr = 5'd9; rs2_raddr = 5'd0;
    settle();
    chk("sb_no_fwd", {31'd0, rs1_busy}, 32'd0);
    tick();
    idle(); rs2_raddr = 5'd9;
    settle();
    chk("sb_set_rs1", {31'd0, rs1_busy}, 32'd1);
    chk("sb_set_rs2", {31'd0, rs2_busy}, 32'd1);
    rs2_raddr = 5'd0;
    #1;
    chk("sb_x0_rs2", {31'd0, rs2_busy}, 32'd0);
    // Long write to 9 clears the bit next cycle.
    tick();
    drive_lg(5'd9, 32'h0000_0099);
    settle();
    chk("sb_clr_same_cycle", {31'd0, rs1_busy}, 32'd1);
    tick();
    idle();
    settle();
    chk("sb_clr", {31'd0, rs1_busy}, 32'd0);
    // Set again, then set and clear together: set wins.
    tick();
    drive_iss(5'd9);
    tick();
    idle(); drive_iss(5'd9); drive_lg(5'd9, 32'h0000_0909);
    settle();
    chk("sb_both_wen", {31'd0, wen}, 32'd1);
    tick();
    idle();
    settle();
    chk("sb_set_wins", {31'd0, rs1_busy}, 32'd1);
    tick();
    drive_lg(5'd9, 32'h0000_0009);
    tick();
    idle();
    settle();
    chk("sb_final_clr", {31'd0, rs1_busy}, 32'd0);

    // Starvation: enqueue rd=3 behind EX, then EX wins 4 more cycles.
    tick();
    drive_ex(5'd4, 32'h4444_0000); drive_lg(5'd3, 32'h0000_0033);
    settle();
    chk("stv_enq_waddr", {27'd0, rd_waddr}, 32'd4);
    chk("stv_enq_ready", {31'd0, lg_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle(); drive_ex(5'd4, 32'h4444_0001 + i);
      settle();
      chk($sformatf("stv_nostall_%0d", i), {31'd0, stall_req}, 32'd0);
    end
    tick();
    settle();
    chk("stv_stall", {31'd0, stall_req}, 32'd1);
    chk("stv_ex_wins", {27'd0, rd_waddr}, 32'd4);
    tick();
    settle();
    chk("stv_stall_sat", {31'd0, stall_req}, 32'd1);
    tick();
    idle();
    settle();
    chk("stv_pop_waddr", {27'd0, rd_waddr}, 32'd3);
    chk("stv_pop_wdata", rd_wdata, 32'h0000_0033);
    chk("stv_pop_stall_still", {31'd0, stall_req}, 32'd1);
    tick();
    settle();
    chk("stv_stall_drop", {31'd0, stall_req}, 32'd0);
    chk("stv_empty_wen", {31'd0, wen}, 32'd0);

    // Full FIFO, pop-and-push in one cycle, pointer wrap.
    tick();
    drive_ex(5'd4, 32'h4); drive_lg(5'd10, 32'h0000_000A);
    tick();
    drive_lg(5'd11, 32'h0000_000B);
    tick();
    drive_lg(5'd12, 32'h0000_000C);
    settle();
    chk("full_ready", {31'd0, lg_ready}, 32'd0);
    chk("full_cnt", {30'd0, dbg_count}, 32'd2);
    tick();
    ex_wen = 1'b0;
    settle();
    chk("full_pop_ready", {31'd0, lg_ready}, 32'd1);
    chk("full_pop_waddr", {27'd0, rd_waddr}, 32'd10);
    tick();
    idle();
    settle();
    chk("full_cnt_kept", {30'd0, dbg_count}, 32'd2);
    chk("wrap_head1", {27'd0, rd_waddr}, 32'd11);
    chk("wrap_data1", rd_wdata, 32'h0000_000B);
    tick();
    settle();
    chk("wrap_head2", {27'd0, rd_waddr}, 32'd12);
    chk("wrap_data2", rd_wdata, 32'h0000_000C);
    tick();
    settle();
    chk("wrap_empty", {31'd0, wen}, 32'd0);

    // x0 handling: EX to x0 yields to FIFO head; lg rd=0 consumed silently.
    tick();
    drive_ex(5'd4, 32'h4); drive_lg(5'd13, 32'h0000_000D);
    tick();
    idle(); drive_ex(5'd0, 32'hDEAD_BEEF);
    settle();
    chk("x0_ex_head_wen", {31'd0, wen}, 32'd1);
    chk("x0_ex_head_waddr", {27'd0, rd_waddr}, 32'd13);
    chk("x0_ex_head_wdata", rd_wdata, 32'h0000_000D);
    tick();
    idle(); drive_ex(5'd4, 32'h4); drive_lg(5'd0, 32'h0000_000E);
    tick();
    idle();
    settle();
    chk("x0_lg_wen", {31'd0, wen}, 32'd0);
    chk("x0_lg_ready", {31'd0, lg_ready}, 32'd1);
    tick();
    settle();
    chk("x0_lg_consumed", {30'd0, dbg_count}, 32'd0);
    drive_lg(5'd0, 32'h0000_000F);
    #1;
    chk("x0_byp_wen", {31'd0, wen}, 32'd0);
    chk("x0_byp_ready", {31'd0, lg_ready}, 32'd1);

    // Reset mid-operation with 2 buffered results and busy bits set.
    tick();
    idle(); drive_iss(5'd14);
    tick();
    drive_iss(5'd15);
    tick();
    idle(); drive_ex(5'd4, 32'h4); drive_lg(5'd14, 32'h0000_0014);
    tick();
    drive_lg(5'd15, 32'h0000_0015);
    tick();
    idle();
    settle();
    chk("mid_pre_cnt", {30'd0, dbg_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_wen", {31'd0, wen}, 32'd0);
    chk("mid_lg_ready", {31'd0, lg_ready}, 32'd1);
    for (int a = 0; a < 32; a++) begin
      rs1_raddr = 5'(a); rs2_raddr = 5'(31 - a);
      #0.1;
      chk($sformatf("mid_rs1_busy_%0d", a), {31'd0, rs1_busy}, 32'd0);
      chk($sformatf("mid_rs2_busy_%0d", a), {31'd0, rs2_busy}, 32'd0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-side front end of the integer register file. It merges single-cycle EX results and long-latency results (load/divide unit) into the single write port: `wen`, `rd_waddr`, `rd_wdata`. A FIFO buffers long-latency results. A busy scoreboard gives ID per-register hazard status for in-flight long-latency destinations.

Parameters:
FIFO_DEPTH, 2, entries in the long-result buffer (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose to EX before `stall_req` asserts

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
ex_wen  input  1  EX result valid this cycle (no backpressure)
ex_rd  input  `RegAddrBus  EX destination register
ex_wdata  input  `RegBus  EX result
lg_valid  input  1  long-latency result valid
lg_ready  output  1  arbiter accepts long-latency result
lg_rd  input  `RegAddrBus  long-latency destination register
lg_wdata  input  `RegBus  long-latency result
iss_valid  input  1  long-latency op issued this cycle
iss_rd  input  `RegAddrBus  its destination register
rs1_raddr  input  `RegAddrBus  ID source 1 address
rs2_raddr  input  `RegAddrBus  ID source 2 address
rs1_busy  output  1  rs1 has pending long-latency write
rs2_busy  output  1  rs2 has pending long-latency write
stall_req  output  1  request pipeline bubble so FIFO can drain
wen  output  1  register file write enable
rd_waddr  output  `RegAddrBus  register file write address
rd_wdata  output  `RegBus  register file write data

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, scoreboard all 0, starve counter 0. While in reset the combinational outputs are forced: `wen`=0, `rd_waddr`=0, `rd_wdata`=0, `lg_ready`=0, `stall_req`=0, `rs*_busy`=0. Reset mid-operation discards buffered results.
- Write port mux, combinational, 0 latency, priority order:
  1. EX when `ex_wen`=1 and `ex_rd`!=0.
  2. Otherwise the FIFO head, when the FIFO is non-empty; the head pops this cycle.
  3. Otherwise the bypass: when the FIFO is empty and `lg_valid`=1, the lg inputs drive the port directly and nothing is enqueued.
  4. Otherwise `wen`=0.
- An EX write to x0 counts as idle. Any selected entry with rd=0 drives `wen`=0 but still pops/accepts.
- `lg_ready` = !rst && (FIFO not full || FIFO pops this cycle). A lg handshake that is not bypassed enqueues at the tail.
- Simultaneous pop and push keep the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard (bit per register, bit 0 hardwired 0):
  - set on `iss_valid` with `iss_rd`!=0;
  - cleared when a long-latency result for that register is written (FIFO pop or bypass);
  - set and clear on the same register in the same cycle: set wins.
- `rsN_busy` = scoreboard[rsN_raddr]. It is registered state only; no same-cycle forwarding (the register file internal bypass covers the write cycle).
- Starve counter:
  - increments when the FIFO is non-empty and EX wins;
  - resets to 0 on a FIFO pop or when the FIFO is empty;
  - saturates at STARVE_MAX.
- `stall_req` = (counter==STARVE_MAX), registered. It deasserts the cycle after the pop.
- Widths: data `RegBus` (32), address `RegAddrBus` (5); no arithmetic beyond pointers and counters.

Optional Feature:
Macro WB_STATS_EN.
- Defined: adds 32-bit outputs `stat_ex_wr`, `stat_lg_wr`, `stat_conflict`. These count EX writes, long writes, and cycles where EX and a pending long result collide. Counters wrap at 2^32 and are cleared by rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset mid-operation: fill FIFO with 2 entries, assert rst one cycle -> next cycle `wen`=0, `lg_ready`=1, `rs1_busy`=0 for all addresses.
- EX only: `ex_wen`=1, `ex_rd`=5, data 0x12345678 -> same cycle `wen`=1, `rd_waddr`=5, `rd_wdata`=0x12345678.
- Bypass: FIFO empty, EX idle, lg_valid with rd=7, data 0xA5A5A5A5 -> `wen`=1 same cycle, `rd_waddr`=7, `rd_wdata`=0xA5A5A5A5, FIFO stays empty.
- Scoreboard:
  - `iss_rd`=9, then rs1_raddr=9 -> `rs1_busy`=1;
  - lg write to 9 -> next cycle `rs1_busy`=0;
  - iss and write to 9 in the same cycle -> busy stays 1.
- Starvation: FIFO holds rd=3, EX writes rd=4 for 4 cycles -> `stall_req`=1; drop ex_wen -> rd=3 written, `stall_req`=0 the next cycle.
- x0: ex_rd=0 with a FIFO entry present -> FIFO head written; lg rd=0 -> `wen`=0, entry consumed, `lg_ready` stays 1.
